// File: rtl/freq_cmd_decoder.sv
// freq_cmd_decoder: assembles a framed I2C byte stream into an atomically updated 32-bit NCO tuning word
module freq_cmd_decoder #(
  parameter logic [7:0]  HEADER       = 8'hAA,
  parameter int          TIMEOUT_CYC  = 61440,
  parameter logic [31:0] DEFAULT_FREQ = 32'd0
) (
  input  logic        sck,
  input  logic        reset,
  input  logic [7:0]  data_wrt,
  input  logic        wrt_tick,
  output logic [31:0] frequency,
  output logic        freq_update,
  output logic        frame_error,
  output logic        busy,
  output logic [7:0]  good_frames
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_nxt;
  logic ff1, ff2, ff3;
  logic [3:0] idx;
  logic [15:0] cnt;
  logic [31:8] shadow;
  logic strobe, last, tmo, commit, abort;
  assign strobe = ff2 & ~ff3;
  assign last = strobe && idx == 4'd9;
  assign tmo = !strobe && cnt == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge sck or posedge reset)
    if (reset) begin
      {ff1, ff2, ff3} <= 3'b000;
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      shadow <= '0;
      frequency <= DEFAULT_FREQ;
      freq_update <= 1'b0;
      frame_error <= 1'b0;
      busy <= 1'b0;
      good_frames <= '0;
    end else begin
      {ff1, ff2, ff3} <= {wrt_tick, ff1, ff2};
      state <= state_nxt;
      busy <= state_nxt == COLLECT;
      freq_update <= commit;
      frame_error <= abort;
      good_frames <= good_frames + 8'(commit);
      frequency <= commit ? {shadow, data_wrt} : frequency;
      cnt <= (state == COLLECT && !strobe) ? cnt + 16'd1 : 16'd0;
      if (state == IDLE && strobe && data_wrt == HEADER)
        idx <= 4'd1;
      else if (state == COLLECT && strobe)
        idx <= idx + 4'd1;
      if (abort)
        shadow <= '0;
      else if (state == COLLECT && strobe) begin
        if (idx == 4'd2) shadow[31:24] <= data_wrt;
        if (idx == 4'd5) shadow[23:16] <= data_wrt;
        if (idx == 4'd7) shadow[15:8] <= data_wrt;
      end
    end
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (strobe && data_wrt == HEADER) ? COLLECT : IDLE;
    else
      state_nxt = (last || tmo) ? IDLE : COLLECT;
  end
  // a strobe on the timeout cycle suppresses the abort because tmo requires !strobe
  always_comb begin
    commit = state == COLLECT && last;
    abort = state == COLLECT && tmo;
  end
endmodule

// File: tb/tb_freq_cmd_decoder.sv
// tb_freq_cmd_decoder: directed frames checked every cycle against a time-based frame model
module tb_freq_cmd_decoder;
  localparam int T = 61440;
  logic sck = 1'b0, reset = 1'b1, wrt_tick = 1'b0;
  logic [7:0] data_wrt = 8'h00;
  logic [31:0] frequency;
  logic freq_update, frame_error, busy;
  logic [7:0] good_frames;
  freq_cmd_decoder dut (
    .sck(sck), .reset(reset), .data_wrt(data_wrt), .wrt_tick(wrt_tick),
    .frequency(frequency), .freq_update(freq_update), .frame_error(frame_error),
    .busy(busy), .good_frames(good_frames)
  );
  always #8 sck = ~sck;
  int errors = 0, checks = 0;
  int cyc = 0, act_at = -10, lat = -1, upd_cnt = 0, err_cnt = 0, err_edge = -1;
  logic [7:0] pend_b;
  always @(posedge sck) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc);
    end
  endtask
  // model: a byte takes effect two edges after the edge that first sees wrt_tick high
  bit m_in, m_upd, m_err;
  int m_pos, m_last;
  logic [31:0] m_word, m_freq;
  logic [7:0] m_good;
  always @(posedge sck or posedge reset)
    if (reset) begin
      m_in = 0; m_pos = 0; m_word = 0; m_freq = 0; m_good = 0; m_upd = 0; m_err = 0;
    end else begin
      m_upd = 0; m_err = 0;
      if (cyc == act_at) begin
        if (!m_in) begin
          if (pend_b == 8'hAA) begin m_in = 1; m_pos = 1; m_last = cyc; end
        end else begin
          m_last = cyc;
          case (m_pos)
            2: m_word[31:24] = pend_b;
            5: m_word[23:16] = pend_b;
            7: m_word[15:8] = pend_b;
            default: ;
          endcase
          if (m_pos == 9) begin
            m_freq = {m_word[31:8], pend_b}; m_upd = 1; m_good = m_good + 8'd1; m_in = 0;
          end else m_pos++;
        end
      end else if (m_in && cyc - m_last == T) begin
        m_err = 1; m_in = 0;
      end
    end
  always @(negedge sck)
    if (!reset) begin
      chk("frequency", frequency, m_freq);
      chk("freq_update", 32'(freq_update), 32'(m_upd));
      chk("frame_error", 32'(frame_error), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_in));
      chk("good_frames", 32'(good_frames), 32'(m_good));
      if (freq_update) upd_cnt++;
      if (frame_error) begin err_cnt++; err_edge = cyc - 1; end
    end
  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    @(negedge sck);
    data_wrt = b; pend_b = b; wrt_tick = 1'b1; act_at = cyc + 2;
    for (int i = 1; i <= hi; i++) begin
      @(posedge sck); #1;
      if (freq_update && lat < 0) lat = i;
    end
    @(negedge sck); wrt_tick = 1'b0;
    repeat (lo) @(negedge sck);
  endtask
  task automatic send_frame(input logic [31:0] w, input logic [7:0] b3, input int hi);
    send_byte(8'hAA, hi, 4); send_byte(8'h00, hi, 4); send_byte(w[31:24], hi, 4);
    send_byte(b3, hi, 4); send_byte(8'h00, hi, 4); send_byte(w[23:16], hi, 4);
    send_byte(8'h00, hi, 4); send_byte(w[15:8], hi, 4); send_byte(8'h00, hi, 4);
    send_byte(w[7:0], hi, 4);
  endtask
  task automatic pulse_reset();
    @(negedge sck); reset = 1'b1;
    @(negedge sck); #1;
    chk("rst_frequency", frequency, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_good", 32'(good_frames), 32'd0);
    chk("rst_update", 32'(freq_update), 32'd0);
    chk("rst_error", 32'(frame_error), 32'd0);
    reset = 1'b0;
  endtask
  int u0, s12;
  initial begin
    repeat (3) @(negedge sck);
    pulse_reset();
    repeat (5) @(negedge sck);
    send_frame(32'h12345678, 8'h00, 3);
    repeat (5) @(negedge sck);
    chk("f1_freq", frequency, 32'h12345678);
    chk("f1_good", 32'(good_frames), 32'd1);
    chk("f1_updates", 32'(upd_cnt), 32'd1);
    chk("f1_busy", 32'(busy), 32'd0);
    send_frame(32'h12345678, 8'hAA, 3);
    repeat (5) @(negedge sck);
    chk("hdr_in_frame_freq", frequency, 32'h12345678);
    chk("hdr_in_frame_good", 32'(good_frames), 32'd2);
    send_byte(8'hAA, 3, 4); send_byte(8'h00, 3, 4); send_byte(8'h12, 3, 4);
    s12 = act_at;
    repeat (T + 20) @(negedge sck);
    chk("tmo_errors", 32'(err_cnt), 32'd1);
    chk("tmo_distance", 32'(err_edge - s12), 32'(T));
    chk("tmo_freq_kept", frequency, 32'h12345678);
    chk("tmo_busy", 32'(busy), 32'd0);
    send_frame(32'h9ABCDEF0, 8'h00, 2);
    repeat (5) @(negedge sck);
    chk("after_tmo_freq", frequency, 32'h9ABCDEF0);
    u0 = upd_cnt;
    send_byte(8'h11, 2, 4); send_byte(8'h22, 2, 4);
    send_frame(32'h0BADF00D, 8'h00, 2);
    repeat (5) @(negedge sck);
    chk("garbage_updates", 32'(upd_cnt - u0), 32'd1);
    chk("garbage_freq", frequency, 32'h0BADF00D);
    // long strobes: a duplicate strobe on byte 2 would shift every later payload slot
    u0 = upd_cnt;
    send_byte(8'hAA, 2, 4); send_byte(8'h00, 2, 4); send_byte(8'hC3, 40, 4);
    send_byte(8'h00, 2, 4); send_byte(8'h00, 2, 4); send_byte(8'h5A, 2, 4);
    send_byte(8'h00, 2, 4); send_byte(8'hE1, 2, 4); send_byte(8'h00, 2, 4);
    lat = -1;
    send_byte(8'h96, 40, 4);
    repeat (5) @(negedge sck);
    chk("hold_freq", frequency, 32'hC35AE196);
    chk("hold_updates", 32'(upd_cnt - u0), 32'd1);
    chk("hold_latency_edges", 32'(lat), 32'd3);
    send_byte(8'hAA, 2, 4); send_byte(8'h00, 2, 4); send_byte(8'h12, 2, 4);
    send_byte(8'h00, 2, 4); send_byte(8'h00, 2, 4); send_byte(8'h34, 2, 4);
    pulse_reset();
    u0 = upd_cnt;
    send_byte(8'h00, 2, 4); send_byte(8'h56, 2, 4); send_byte(8'h00, 2, 4); send_byte(8'h78, 2, 4);
    repeat (5) @(negedge sck);
    chk("post_rst_updates", 32'(upd_cnt - u0), 32'd0);
    chk("post_rst_freq", frequency, 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 256; i++) begin
      send_frame(32'(i) * 32'h01010101, 8'h00, 2);
      if (i == 254) chk("good_255", 32'(good_frames), 32'd255);
    end
    repeat (5) @(negedge sck);
    chk("wrap_good", 32'(good_frames), 32'd0);
    chk("wrap_freq", frequency, 32'hFFFFFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
